// File: rtl/bw_ictag_nway.sv
// bw_ictag_nway -- N-way instruction-cache tag store.
//
// Holds one tag per way per set, gated by a valid bit. Lookups are registered:
// hit/hit_way appear one cycle after rd and hold until the next rd. Fills go
// either to an explicit way or to the per-set round-robin victim. A single
// line can be invalidated by address, and inv_all starts a sweep that clears
// one set per cycle for LINES cycles. An even-bank instance (evn=1) adds
// ip[LINE_BITS-1] to the lookup index so two instances can serve a split
// even/odd fetch.
//
// Optional feature macro: BW_ICTAG_PARITY_EN
//   Adds an even-parity bit per tag entry, the perr output and the par_inj
//   input. A tag match with bad parity is reported as a miss plus perr, and
//   the failing entry is dropped.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   evn               even-bank instance (index += ip[LINE_BITS-1])
//   rd, ip            lookup request and address
//   hit, hit_way      registered lookup result (hit_way = lowest hit, 0 on miss)
//   victim_way        round-robin victim of wr_adr's set (combinational)
//   wr, wr_auto       fill strobe; 1 = fill into victim_way, 0 = into wr_way
//   wr_way, wr_adr    explicit fill way, fill address
//   inv_line, inv_adr invalidate every way of inv_adr's set holding its tag
//   inv_all           start a whole-cache flush (pulse)
//   busy              flush sweep in progress
//   perr, par_inj     (parity build only) parity error pulse, parity inject
module bw_ictag_nway #(
  parameter int WAYS      = 4,
  parameter int LINES     = 128,
  parameter int AWID      = 32,
  parameter int LINE_BITS = 7,
  parameter int IDXW      = $clog2(LINES),
  parameter int WAYW      = $clog2(WAYS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            evn,
  input  logic            rd,
  input  logic [AWID-1:0] ip,
  output logic            hit,
  output logic [WAYW-1:0] hit_way,
  output logic [WAYW-1:0] victim_way,
  input  logic            wr,
  input  logic            wr_auto,
  input  logic [WAYW-1:0] wr_way,
  input  logic [AWID-1:0] wr_adr,
  input  logic            inv_line,
  input  logic [AWID-1:0] inv_adr,
  input  logic            inv_all,
  output logic            busy
`ifdef BW_ICTAG_PARITY_EN
  ,
  output logic            perr,
  input  logic            par_inj
`endif
);

  localparam int TAGW = AWID - LINE_BITS;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SWEEP = 1'b1} fl_state_t;

  function automatic logic [IDXW-1:0] idx_of(input logic [AWID-1:0] adr);
    idx_of = adr[LINE_BITS+IDXW-1:LINE_BITS];
  endfunction

  function automatic logic [TAGW-1:0] tag_of(input logic [AWID-1:0] adr);
    tag_of = adr[AWID-1:LINE_BITS];
  endfunction

  // Even parity: the stored bit makes {tag, bit} have an even number of ones.
  function automatic logic par_of(input logic [TAGW-1:0] t);
    par_of = ^t;
  endfunction

  // Storage. Tag contents are never reset; valid bits gate them.
  logic [TAGW-1:0] tag_mem_r [WAYS][LINES];
  logic [WAYS-1:0] valid_r   [LINES];
  logic [WAYW-1:0] vptr_r    [LINES];
`ifdef BW_ICTAG_PARITY_EN
  logic            par_mem_r [WAYS][LINES];
  logic [WAYS-1:0] perr_way_s;
  logic [WAYS-1:0] pclr_mask_s;
  logic            perr_r;
`endif

  fl_state_t       state_r, state_nxt_s;
  logic [IDXW-1:0] cnt_r, cnt_nxt_s;
  logic            busy_r;
  logic            sweep_s;

  logic [IDXW-1:0] lk_idx_s, wr_idx_s, inv_idx_s;
  logic [TAGW-1:0] lk_tag_s, wr_tag_s, inv_tag_s;
  logic [WAYS-1:0] match_s, set_mask_s, inv_mask_s;
  logic [WAYW-1:0] fill_way_s, hit_way_s;
  logic            hit_s, fill_en_s;
  logic            hit_r;
  logic [WAYW-1:0] hit_way_r;
  logic            unused_ok_s;

  // Offset bits below the line never take part in tag or index.
  assign unused_ok_s = ^{ip[LINE_BITS-2:0], wr_adr[LINE_BITS-1:0], inv_adr[LINE_BITS-1:0]};

  assign sweep_s    = (state_r == ST_SWEEP);
  // The odd half-line of an even bank lives in the next set; the tag is not adjusted.
  assign lk_idx_s   = idx_of(ip) + IDXW'(evn & ip[LINE_BITS-1]);
  assign lk_tag_s   = tag_of(ip);
  assign wr_idx_s   = idx_of(wr_adr);
  assign wr_tag_s   = tag_of(wr_adr);
  assign inv_idx_s  = idx_of(inv_adr);
  assign inv_tag_s  = tag_of(inv_adr);
  assign victim_way = vptr_r[wr_idx_s];
  assign fill_en_s  = wr & ~sweep_s;
  assign fill_way_s = wr_auto ? vptr_r[wr_idx_s] : wr_way;
  assign hit        = hit_r;
  assign hit_way    = hit_way_r;
  assign busy       = busy_r;
`ifdef BW_ICTAG_PARITY_EN
  assign perr       = perr_r;
`endif

  // Per-way tag compare against the pre-edge array contents.
  always_comb begin
    match_s = '0;
`ifdef BW_ICTAG_PARITY_EN
    perr_way_s = '0;
`endif
    for (int w = 0; w < WAYS; w++) begin
      if (valid_r[lk_idx_s][w] && (tag_mem_r[w][lk_idx_s] == lk_tag_s)) begin
`ifdef BW_ICTAG_PARITY_EN
        if (par_mem_r[w][lk_idx_s] != par_of(lk_tag_s)) begin
          perr_way_s[w] = 1'b1;
        end else begin
          match_s[w] = 1'b1;
        end
`else
        match_s[w] = 1'b1;
`endif
      end else begin
        match_s[w] = 1'b0;
      end
    end
  end

  // Priority encode: scanning downward leaves the lowest matching way.
  always_comb begin
    hit_way_s = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (match_s[w]) begin
        hit_way_s = WAYW'(w);
      end else begin
        hit_way_s = hit_way_s;
      end
    end
    hit_s = |match_s;
  end

  // Valid-bit set/clear masks; an invalidate beats a fill to the same entry.
  always_comb begin
    set_mask_s = '0;
    inv_mask_s = '0;
    if (fill_en_s) begin
      set_mask_s[fill_way_s] = 1'b1;
    end else begin
      set_mask_s = '0;
    end
    for (int w = 0; w < WAYS; w++) begin
      if (inv_line && !sweep_s &&
          ((tag_mem_r[w][inv_idx_s] == inv_tag_s) ||
           (set_mask_s[w] && (wr_idx_s == inv_idx_s) && (wr_tag_s == inv_tag_s)))) begin
        inv_mask_s[w] = 1'b1;
      end else begin
        inv_mask_s[w] = 1'b0;
      end
    end
`ifdef BW_ICTAG_PARITY_EN
    if (rd && !sweep_s) begin
      pclr_mask_s = perr_way_s;
    end else begin
      pclr_mask_s = '0;
    end
`endif
  end

  // Tag (and parity) array write port; no reset on the data itself.
  always_ff @(posedge clk) begin
    if (fill_en_s) begin
      tag_mem_r[fill_way_s][wr_idx_s] <= wr_tag_s;
`ifdef BW_ICTAG_PARITY_EN
      par_mem_r[fill_way_s][wr_idx_s] <= par_of(wr_tag_s) ^ par_inj;
`endif
    end
  end

  // Valid bits and victim pointers: sweep, fill, invalidate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LINES; i++) begin
        valid_r[i] <= '0;
        vptr_r[i]  <= '0;
      end
    end else if (sweep_s) begin
      valid_r[cnt_r] <= '0;
      vptr_r[cnt_r]  <= '0;
    end else begin
      for (int i = 0; i < LINES; i++) begin
        valid_r[i] <= (valid_r[i] | ((wr_idx_s == IDXW'(i)) ? set_mask_s : {WAYS{1'b0}}))
                    & ~((inv_idx_s == IDXW'(i)) ? inv_mask_s : {WAYS{1'b0}})
`ifdef BW_ICTAG_PARITY_EN
                    & ~((lk_idx_s == IDXW'(i)) ? pclr_mask_s : {WAYS{1'b0}})
`endif
                    ;
      end
      if (fill_en_s && wr_auto) begin
        vptr_r[wr_idx_s] <= vptr_r[wr_idx_s] + WAYW'(1);
      end
    end
  end

  // Registered lookup result; holds between lookups, forced to a miss during a sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_r     <= 1'b0;
      hit_way_r <= '0;
    end else if (rd) begin
      if (sweep_s) begin
        hit_r     <= 1'b0;
        hit_way_r <= '0;
      end else begin
        hit_r     <= hit_s;
        hit_way_r <= hit_way_s;
      end
    end else begin
      hit_r     <= hit_r;
      hit_way_r <= hit_way_r;
    end
  end

`ifdef BW_ICTAG_PARITY_EN
  // Parity error pulse, one cycle, aligned with the lookup result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perr_r <= 1'b0;
    end else begin
      perr_r <= rd & ~sweep_s & (|perr_way_s);
    end
  end
`endif

  // Flush sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      busy_r  <= (state_nxt_s == ST_SWEEP);
    end
  end

  // Flush sequencer next state: one set per cycle, LINES cycles total.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (inv_all) begin
          state_nxt_s = ST_SWEEP;
          cnt_nxt_s   = '0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SWEEP: begin
        cnt_nxt_s = cnt_r + IDXW'(1);
        if (cnt_r == IDXW'(LINES - 1)) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_SWEEP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_bw_ictag_nway.sv
// Self-checking bench for bw_ictag_nway (default parameters: 4 ways, 128 sets,
// 128-byte lines). Lookups are checked by a scoreboard: each rd pushes its
// expected result, and a monitor pops and compares one cycle later.
module tb_bw_ictag_nway;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        evn = 1'b0;
  logic        rd = 1'b0;
  logic [31:0] ip = 32'h0;
  logic        hit;
  logic [1:0]  hit_way;
  logic [1:0]  victim_way;
  logic        wr = 1'b0;
  logic        wr_auto = 1'b0;
  logic [1:0]  wr_way = 2'd0;
  logic [31:0] wr_adr = 32'h0;
  logic        inv_line = 1'b0;
  logic [31:0] inv_adr = 32'h0;
  logic        inv_all = 1'b0;
  logic        busy;
`ifdef BW_ICTAG_PARITY_EN
  logic        perr;
  logic        par_inj = 1'b0;
`endif

  typedef struct packed {
    logic       h;
    logic [1:0] w;
    logic       p;
  } exp_t;

  exp_t  exp_q[$];
  string nm_q[$];
  int    total = 0;
  int    bad = 0;
  logic  rd_q = 1'b0;

  bw_ictag_nway dut (
    .clk(clk), .rst_n(rst_n), .evn(evn), .rd(rd), .ip(ip),
    .hit(hit), .hit_way(hit_way), .victim_way(victim_way),
    .wr(wr), .wr_auto(wr_auto), .wr_way(wr_way), .wr_adr(wr_adr),
    .inv_line(inv_line), .inv_adr(inv_adr), .inv_all(inv_all), .busy(busy)
`ifdef BW_ICTAG_PARITY_EN
    , .perr(perr), .par_inj(par_inj)
`endif
  );

  always #5 clk = ~clk;

  // Monitor: note which edges carried a lookup, compare on the falling edge after.
  always @(posedge clk) rd_q <= rd;

  always @(negedge clk) begin
    if (rd_q) begin
      total = total + 1;
      if (exp_q.size() == 0) begin
        bad = bad + 1;
        $display("FAIL lookup_unexpected: got hit=%0b way=%0d with no expectation queued", hit, hit_way);
      end else begin
        exp_t  e;
        string n;
        logic  p_ok;
        e = exp_q.pop_front();
        n = nm_q.pop_front();
        p_ok = 1'b1;
`ifdef BW_ICTAG_PARITY_EN
        p_ok = (perr === e.p);
`endif
        if (hit !== e.h || hit_way !== e.w || !p_ok) begin
          bad = bad + 1;
`ifdef BW_ICTAG_PARITY_EN
          $display("FAIL %s: got hit=%0b way=%0d perr=%0b, want hit=%0b way=%0d perr=%0b",
                   n, hit, hit_way, perr, e.h, e.w, e.p);
`else
          $display("FAIL %s: got hit=%0b way=%0d, want hit=%0b way=%0d", n, hit, hit_way, e.h, e.w);
`endif
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total = total + 1;
    if (act !== want) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h, want %0h", nm, act, want);
    end
  endtask

  task automatic push_exp(input string nm, input logic h, input logic [1:0] w, input logic p);
    exp_t e;
    e.h = h;
    e.w = w;
    e.p = p;
    exp_q.push_back(e);
    nm_q.push_back(nm);
  endtask

  task automatic lookup(input string nm, input logic [31:0] a, input logic h,
                        input logic [1:0] w, input logic p);
    rd = 1'b1;
    ip = a;
    push_exp(nm, h, w, p);
    step();
    rd = 1'b0;
  endtask

  task automatic fill(input logic [31:0] a, input logic au, input logic [1:0] w);
    wr = 1'b1;
    wr_auto = au;
    wr_way = w;
    wr_adr = a;
    step();
    wr = 1'b0;
    wr_auto = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt;
    // Reset state.
    repeat (3) step();
    chk("rst_hit", {31'd0, hit}, 32'd0);
    chk("rst_way", {30'd0, hit_way}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    step();
    lookup("rd_after_reset", 32'h0000_1080, 1'b0, 2'd0, 1'b0);
    chk("busy_idle", {31'd0, busy}, 32'd0);

    // Four round-robin fills of one set: victim goes 0,1,2,3 then wraps to 0.
    for (int k = 0; k < 4; k++) begin
      wr = 1'b1; wr_auto = 1'b1; wr_adr = 32'h0000_1080;
      #1;
      chk("victim_seq", {30'd0, victim_way}, k);
      step();
      wr = 1'b0; wr_auto = 1'b0;
    end
    #1;
    chk("victim_wrap", {30'd0, victim_way}, 32'd0);
    lookup("rd_multi_lowest", 32'h0000_1080, 1'b1, 2'd0, 1'b0);
    step(); step();
    chk("hit_hold", {31'd0, hit}, 32'd1);

    // Invalidate and fill of the same entry on one edge: the invalidate wins.
    fill(32'h0000_1080, 1'b0, 2'd0);
    wr = 1'b1; wr_way = 2'd0; wr_adr = 32'h0000_1080;
    inv_line = 1'b1; inv_adr = 32'h0000_1080;
    step();
    wr = 1'b0; inv_line = 1'b0;
    lookup("inv_beats_wr", 32'h0000_1080, 1'b0, 2'd0, 1'b0);
    // Different entries on one edge: both act.
    fill(32'h0000_1080, 1'b0, 2'd2);
    wr = 1'b1; wr_way = 2'd1; wr_adr = 32'h0000_2080;
    inv_line = 1'b1; inv_adr = 32'h0000_1080;
    step();
    wr = 1'b0; inv_line = 1'b0;
    lookup("fill_way1", 32'h0000_2080, 1'b1, 2'd1, 1'b0);
    lookup("inv_other_set", 32'h0000_1080, 1'b0, 2'd0, 1'b0);
    wr_adr = 32'h0000_1080;
    #1;
    chk("victim_explicit_unchanged", {30'd0, victim_way}, 32'd0);

    // A lookup on the same edge as a fill sees the old contents.
    wr = 1'b1; wr_auto = 1'b1; wr_adr = 32'h0000_4080;
    lookup("no_bypass", 32'h0000_4080, 1'b0, 2'd0, 1'b0);
    wr = 1'b0; wr_auto = 1'b0;
    lookup("after_fill", 32'h0000_4080, 1'b1, 2'd0, 1'b0);

    // Even-bank index increment and wrap.
    evn = 1'b1;
    fill(32'h0000_0100, 1'b1, 2'd0);
    lookup("evn_no_inc", 32'h0000_0100, 1'b1, 2'd0, 1'b0);
    lookup("evn_inc_next_set", 32'h0000_0140, 1'b0, 2'd0, 1'b0);
    evn = 1'b0;
    lookup("odd_same_set", 32'h0000_0140, 1'b1, 2'd0, 1'b0);
    fill(32'h0000_3F80, 1'b0, 2'd3);
    lookup("odd_top_set", 32'h0000_3FC0, 1'b1, 2'd3, 1'b0);
    evn = 1'b1;
    lookup("evn_wrap_set0", 32'h0000_3FC0, 1'b0, 2'd0, 1'b0);
    evn = 1'b0;

    // Whole-cache flush.
    for (int k = 0; k < 20; k++) fill(32'h0000_8000 + k * 32'h80, 1'b1, 2'd0);
    lookup("pre_flush", 32'h0000_8980, 1'b1, 2'd0, 1'b0);
    inv_all = 1'b1;
    step();
    inv_all = 1'b0;
    busy_cnt = 0;
    while (busy === 1'b1 && busy_cnt < 300) begin
      busy_cnt = busy_cnt + 1;
      rd = 1'b0; wr = 1'b0; wr_auto = 1'b0; inv_all = 1'b0; inv_line = 1'b0;
      if (busy_cnt == 3) begin
        rd = 1'b1; ip = 32'h0000_8980;
        push_exp("rd_during_sweep", 1'b0, 2'd0, 1'b0);
      end
      if (busy_cnt == 60) begin
        wr = 1'b1; wr_auto = 1'b1; wr_adr = 32'h0000_C280;
      end
      if (busy_cnt == 70) inv_all = 1'b1;
      step();
    end
    rd = 1'b0; wr = 1'b0; wr_auto = 1'b0; inv_all = 1'b0;
    chk("busy_cycles", busy_cnt, 32'd128);
    for (int k = 0; k < 20; k++) lookup("after_flush", 32'h0000_8000 + k * 32'h80, 1'b0, 2'd0, 1'b0);
    lookup("wr_in_sweep_ignored", 32'h0000_C280, 1'b0, 2'd0, 1'b0);
    lookup("old_line_flushed", 32'h0000_2080, 1'b0, 2'd0, 1'b0);
    for (int s = 0; s < 128; s++) begin
      wr_adr = s * 32'h80;
      #1;
      chk("victim_zero_after_flush", {30'd0, victim_way}, 32'd0);
    end
    step();

    // Reset in the middle of a sweep aborts it.
    inv_all = 1'b1;
    step();
    inv_all = 1'b0;
    repeat (10) step();
    rst_n = 1'b0;
    #1;
    chk("busy_abort", {31'd0, busy}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("busy_after_abort", {31'd0, busy}, 32'd0);

`ifdef BW_ICTAG_PARITY_EN
    par_inj = 1'b1;
    fill(32'h0000_1080, 1'b1, 2'd0);
    par_inj = 1'b0;
    lookup("par_err", 32'h0000_1080, 1'b0, 2'd0, 1'b1);
    lookup("par_cleared", 32'h0000_1080, 1'b0, 2'd0, 1'b0);
    fill(32'h0000_2080, 1'b1, 2'd0);
    lookup("par_good", 32'h0000_2080, 1'b1, 2'd0, 1'b0);
`endif

    repeat (3) step();
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
